// File: rtl/qmem_master_pipe.sv
// QMEM bus master: command FIFO, back-to-back pipelined accesses, one response per command.
// Optional ack timeout is compiled in with QMEM_MASTER_PIPE_TIMEOUT_EN.
module qmem_master_pipe #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8,
  parameter int CD  = 4,
  parameter int AD  = 10
) (
  input  logic           clk,
  input  logic           rst,
  // command side
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic           cmd_we,
  input  logic [QSW-1:0] cmd_sel,
  input  logic [QAW-1:0] cmd_adr,
  input  logic [QDW-1:0] cmd_dat,
  // response side
  output logic           rsp_vld,
  output logic           rsp_we,
  output logic [QDW-1:0] rsp_dat,
  output logic           rsp_err,
  output logic           rsp_tout,
  // QMEM request / response
  output logic           cs,
  output logic           we,
  output logic [QSW-1:0] sel,
  output logic [QAW-1:0] adr,
  output logic [QDW-1:0] dat_w,
  input  logic [QDW-1:0] dat_r,
  input  logic           ack,
  input  logic           err,
  // status
  output logic           busy,
  output logic           error,
  input  logic           error_clr
);

  localparam int PW = $clog2(CD);

  typedef struct packed {
    logic           we;
    logic [QSW-1:0] sel;
    logic [QAW-1:0] adr;
    logic [QDW-1:0] dat;
  } cmd_t;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  cmd_t   mem [CD];
  cmd_t   head;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   term;
  logic   tout_hit;
  logic   fault;
  state_t state;

  logic   pend;
  logic   pend_we;
  logic   pend_err;
  logic   pend_tout;
  logic   rsp_tout_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_rdy = !full;
  assign push    = cmd_vld && !full;
  assign head    = mem[rd_ptr[PW-1:0]];

  assign term  = (state == ACCESS) && (ack || err || tout_hit);
  assign pop   = !empty && ((state == IDLE) || term);
  assign fault = term && (err || (tout_hit && !ack));
  assign busy  = !empty || cs || pend;

  // NOTE: FIFO storage carries no reset; the pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Request FSM: a pop either starts a new access or replaces the one ending at this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cs    <= 1'b0;
      we    <= 1'b0;
      sel   <= '0;
      adr   <= '0;
      dat_w <= '0;
    end else begin
      if (pop) begin
        state <= ACCESS;
        cs    <= 1'b1;
        we    <= head.we;
        sel   <= head.sel;
        adr   <= head.adr;
        dat_w <= head.dat;
      end else if (term) begin
        state <= IDLE;
        cs    <= 1'b0;
      end
    end
  end

`ifdef QMEM_MASTER_PIPE_TIMEOUT_EN
  localparam int TW = $clog2(AD + 1);

  logic [TW-1:0] tcnt;

  // Terminates on the edge that would bring the count of silent cs cycles up to AD.
  assign tout_hit = cs && (tcnt == TW'(AD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (pop) begin
      tcnt <= '0;
    end else if (cs && !ack && !err && !tout_hit) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tout_hit = 1'b0;
`endif

  // Response stage: cause latched at the termination edge, pulse one edge later with dat_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
      pend_tout  <= 1'b0;
      rsp_vld    <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_dat    <= '0;
      rsp_err    <= 1'b0;
      rsp_tout_q <= 1'b0;
    end else begin
      pend <= term;
      if (term) begin
        pend_we   <= we;
        pend_err  <= err;
        pend_tout <= tout_hit && !ack && !err;
      end
      rsp_vld <= pend;
      if (pend) begin
        rsp_we     <= pend_we;
        rsp_dat    <= pend_we ? '0 : dat_r;
        rsp_err    <= pend_err;
        rsp_tout_q <= pend_tout;
      end else begin
        rsp_we     <= 1'b0;
        rsp_dat    <= '0;
        rsp_err    <= 1'b0;
        rsp_tout_q <= 1'b0;
      end
    end
  end

  assign rsp_tout = rsp_tout_q;

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error <= 1'b0;
    end else if (fault) begin
      error <= 1'b1;
    end else if (error_clr) begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qmem_master_pipe.sv
// Directed bench for qmem_master_pipe: behavioural QMEM slave plus a response scoreboard.
`timescale 1ns/1ps
module tb_qmem_master_pipe;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int CD  = 4;
  localparam int AD  = 10;
  localparam logic [31:0] RD_MASK = 32'hA5A5A5A5;
  localparam logic [31:0] NO_DATA = 32'hBAD0BAD0;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_vld = 1'b0;
  logic           cmd_rdy;
  logic           cmd_we = 1'b0;
  logic [QSW-1:0] cmd_sel = '0;
  logic [QAW-1:0] cmd_adr = '0;
  logic [QDW-1:0] cmd_dat = '0;
  logic           rsp_vld;
  logic           rsp_we;
  logic [QDW-1:0] rsp_dat;
  logic           rsp_err;
  logic           rsp_tout;
  logic           cs;
  logic           we;
  logic [QSW-1:0] sel;
  logic [QAW-1:0] adr;
  logic [QDW-1:0] dat_w;
  logic [QDW-1:0] dat_r;
  logic           ack;
  logic           err;
  logic           busy;
  logic           error;
  logic           error_clr = 1'b0;

  qmem_master_pipe #(
    .QAW(QAW), .QDW(QDW), .QSW(QSW), .CD(CD), .AD(AD)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_vld(rsp_vld), .rsp_we(rsp_we), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_tout(rsp_tout),
    .cs(cs), .we(we), .sel(sel), .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
    .ack(ack), .err(err),
    .busy(busy), .error(error), .error_clr(error_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] dat;
    logic        err;
    logic        tout;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: acks after slave_wait silent cycles, answers err on access err_idx,
  // and drives dat_r = adr ^ RD_MASK only in the cycle after a termination.
  int          slave_wait = 0;
  bit          hang = 1'b0;
  int          acc_idx = 0;
  int          err_idx = -1;
  int          wcnt = 0;
  logic        prev_term = 1'b0;
  logic [31:0] prev_adr = '0;

  initial begin
    ack   = 1'b0;
    err   = 1'b0;
    dat_r = '0;
    forever begin
      @(negedge clk);
      dat_r = prev_term ? (prev_adr ^ RD_MASK) : NO_DATA;
      ack = 1'b0;
      err = 1'b0;
      if (rst && cs && !hang && wcnt >= slave_wait) begin
        if (acc_idx == err_idx) err = 1'b1;
        else                    ack = 1'b1;
      end
      prev_term = ack || err;
      prev_adr  = adr;
      if (rst && cs) begin
        if (ack || err) begin
          wcnt = 0;
          acc_idx++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Bus and response monitor.
  int          cs_cycles = 0;
  int          cs_rises = 0;
  int          rsp_seen = 0;
  int          rsp_rises = 0;
  logic        cs_prev = 1'b0;
  logic        rsp_prev = 1'b0;
  logic [31:0] cs_log[$];
  logic        last_we = 1'b0;
  logic [3:0]  last_sel = '0;
  logic [31:0] last_dat_w = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cs) begin
        cs_cycles++;
        if (!cs_prev) cs_rises++;
        cs_log.push_back(adr);
        last_we    = we;
        last_sel   = sel;
        last_dat_w = dat_w;
      end
      cs_prev = cs;
      if (rsp_vld) begin
        rsp_seen++;
        if (!rsp_prev) rsp_rises++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_vld), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_we",   64'(rsp_we),   64'(e.we));
          check("rsp_dat",  64'(rsp_dat),  64'(e.dat));
          check("rsp_err",  64'(rsp_err),  64'(e.err));
          check("rsp_tout", 64'(rsp_tout), 64'(e.tout));
        end
      end
      rsp_prev = rsp_vld;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cs_cycles = 0;
    cs_rises  = 0;
    rsp_seen  = 0;
    rsp_rises = 0;
    cs_log.delete();
  endtask

  // Drives one command, waits (bounded) for cmd_rdy, returns just after the accepting edge.
  task automatic push(input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input bit expect_rsp,
                      input logic e_err, input logic e_tout);
    exp_t e;
    step();
    cmd_vld = 1'b1;
    cmd_we  = w;
    cmd_sel = s;
    cmd_adr = a;
    cmd_dat = d;
    for (int i = 0; i < 50 && !cmd_rdy; i++) step();
    check("push_accept", 64'(cmd_rdy), 64'd1);
    if (expect_rsp) begin
      e.we   = w;
      e.dat  = w ? 32'h0 : (e_tout ? NO_DATA : (a ^ RD_MASK));
      e.err  = e_err;
      e.tout = e_tout;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && rsp_seen < n; i++) step();
    step();
    step();
    check("rsp_count", 64'(rsp_seen), 64'(n));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cs",      64'(cs),      64'd0);
    check("rst_we",      64'(we),      64'd0);
    check("rst_sel",     64'(sel),     64'd0);
    check("rst_adr",     64'(adr),     64'd0);
    check("rst_dat_w",   64'(dat_w),   64'd0);
    check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_error",   64'(error),   64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    step();
    rst = 1'b1;
    step();

    // Single write, slave acks after 2 wait cycles
    clear_mon();
    slave_wait = 2;
    push(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step();
    check("t1_cs_latency0", 64'(cs), 64'd0);
    step();
    check("t1_cs_latency1", 64'(cs), 64'd1);
    wait_rsp(1);
    check("t1_cs_cycles", 64'(cs_cycles), 64'd3);
    check("t1_cs_rises",  64'(cs_rises),  64'd1);
    check("t1_adr",       64'(cs_log[0]), 64'h100);
    check("t1_we",        64'(last_we),   64'd1);
    check("t1_sel",       64'(last_sel),  64'hF);
    check("t1_dat_w",     64'(last_dat_w), 64'hDEADBEEF);
    check("t1_cs_drop",   64'(cs),        64'd0);
    check("t1_adr_hold",  64'(adr),       64'h100);
    check("t1_busy_idle", 64'(busy),      64'd0);

    // Four back-to-back reads to a zero-wait slave
    clear_mon();
    slave_wait = 0;
    for (int i = 0; i < 4; i++) push(1'b0, 4'hF, 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0);
    wait_rsp(4);
    check("t2_cs_cycles",  64'(cs_cycles), 64'd4);
    check("t2_cs_rises",   64'(cs_rises),  64'd1);
    check("t2_rsp_rises",  64'(rsp_rises), 64'd1);
    for (int i = 0; i < 4; i++) check("t2_adr_seq", 64'(cs_log[i]), 64'(i * 4));

    // FIFO fill against a stalled slave
    clear_mon();
    hang = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 4'h3, 32'h200 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0);
      check("t3_rdy_during_fill", 64'(cmd_rdy), (i == 4) ? 64'd0 : 64'd1);
    end
    step();
    step();
    step();
    check("t3_rdy_held",  64'(cmd_rdy), 64'd0);
    check("t3_cs_stall",  64'(cs),      64'd1);
    check("t3_busy",      64'(busy),    64'd1);
    hang = 1'b0;
    push(1'b0, 4'h3, 32'h214, 32'h0, 1'b1, 1'b0, 1'b0);
    wait_rsp(6);
    check("t3_adr_first", 64'(cs_log[0]), 64'h200);

    // err on the 2nd of 3 writes
    clear_mon();
    check("t4_error_pre", 64'(error), 64'd0);
    err_idx = acc_idx + 1;
    push(1'b1, 4'hF, 32'h400, 32'h11111111, 1'b1, 1'b0, 1'b0);
    push(1'b1, 4'hF, 32'h404, 32'h22222222, 1'b1, 1'b1, 1'b0);
    push(1'b1, 4'hF, 32'h408, 32'h33333333, 1'b1, 1'b0, 1'b0);
    wait_rsp(3);
    check("t4_cs_cycles",   64'(cs_cycles), 64'd3);
    check("t4_third_adr",   64'(cs_log[2]), 64'h408);
    check("t4_error_set",   64'(error),     64'd1);
    step();
    step();
    check("t4_error_sticky", 64'(error),    64'd1);
    error_clr = 1'b1;
    step();
    error_clr = 1'b0;
    check("t4_error_clr",   64'(error),     64'd0);
    err_idx = -1;

    // No ack: timeout or indefinite wait
    clear_mon();
    hang = 1'b1;
`ifdef QMEM_MASTER_PIPE_TIMEOUT_EN
    push(1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1);
    wait_rsp(1);
    check("t5_cs_cycles", 64'(cs_cycles), 64'(AD));
    check("t5_error",     64'(error),     64'd1);
    error_clr = 1'b1;
    step();
    error_clr = 1'b0;
`else
    push(1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 110; i++) step();
    check("t5_cs_held",   64'(cs),               64'd1);
    check("t5_cs_100",    64'(cs_cycles >= 100), 64'd1);
    check("t5_no_rsp",    64'(rsp_seen),         64'd0);
    check("t5_no_tout",   64'(rsp_tout),         64'd0);
`endif

    // Reset in the middle of an access with commands queued
    push(1'b0, 4'hF, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 4'hF, 32'h504, 32'h0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 4'hF, 32'h508, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("t6_cs_pre",   64'(cs),   64'd1);
    check("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_cs_async",  64'(cs),      64'd0);
    check("t6_busy_rst",  64'(busy),    64'd0);
    check("t6_rdy_rst",   64'(cmd_rdy), 64'd1);
    check("t6_error_rst", 64'(error),   64'd0);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) step();
    check("t6_no_rsp",   64'(rsp_seen),  64'd0);
    check("t6_no_cs",    64'(cs_cycles), 64'd0);
    check("t6_busy_end", 64'(busy),      64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
